lfsr_gen: RTL and testbench
===========================

Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR with:
  - forward and reverse stepping,
  - synchronous seed/load,
  - all-zero lock-up recovery,
  - period measurement,
  - hex 7-segment outputs for every state nibble.
- Sits between board switches/buttons and the seven-segment bank in the NPC demo top.
- Also serves as a pseudo-random source for other demo blocks.

Parameters:
- WIDTH, 8: LFSR width in bits; legal range 3..32.
- TAP_MASK, 8'h1D: feedback taps; bit i set means state[i] enters the XOR. Bit 0 must be 1.
- SEED, 8'h03: value loaded at reset and on lock-up recovery. Must be non-zero.
- NDIG, (WIDTH+3)/4: number of hex digits driven.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  step enable; one step per cycle when high.
- dir  in  1  0 = forward step, 1 = reverse step.
- load  in  1  load load_data into the state.
- load_data  in  WIDTH  value for load.
- clear  in  1  blank all displays.
- state  out  WIDTH  current LFSR state (registered).
- lockup  out  1  high while state == 0.
- wrap  out  1  one-cycle pulse when a step lands on SEED.
- period  out  WIDTH  step count of the last completed cycle back to SEED.
- seg  out  7*NDIG  active-low segments; digit k occupies seg[7k+6:7k]; bit 0 = a … bit 6 = g.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset values:
  - state = SEED, internal step_cnt = 0, wrap = 0, period = 0.
  - lockup = 0, because SEED is non-zero.
- Forward step:
  - fb = XOR of (state & TAP_MASK).
  - next = {fb, state[WIDTH-1:1]}.
- Reverse step (exact inverse of forward):
  - prev[WIDTH-1:1] = state[WIDTH-2:0].
  - prev[0] = state[WIDTH-1] XOR (XOR over i ≥ 1 with TAP_MASK[i] set of state[i-1]).
- Priority per cycle: rst > load > en > hold.
- Load:
  - state = load_data, step_cnt = 0, wrap = 0.
  - period is unchanged.
  - load_data = 0 is accepted and produces lock-up.
- Step with state == 0:
  - state = SEED, step_cnt = 0, wrap = 0. No period update.
  - Recovery takes exactly one enabled cycle.
- Normal step:
  - state = next (or prev when dir = 1).
  - If the new value equals SEED: wrap = 1 that cycle, period = step_cnt + 1, step_cnt = 0.
  - Otherwise step_cnt = step_cnt + 1 and wrap = 0.
  - step_cnt is WIDTH bits and saturates at all-ones; it never wraps.
- dir may change on any cycle and takes effect on that cycle's step. step_cnt counts steps in either direction without distinction.
- en = 0 and load = 0: state, step_cnt and period hold; wrap = 0.
- Loading SEED itself does not pulse wrap.
- lockup: combinational, (state == 0).
- seg (combinational from state and clear):
  - Digit k shows nibble state[4k+3:4k]; the top digit is zero-extended when WIDTH % 4 ≠ 0.
  - Hex codes 0–F use standard 7-seg glyphs (b, d lowercase), active-low.
  - clear = 1 forces every digit to 7'h7F (blank). clear does not affect any register.
- Latency: state, wrap and period update on the clock edge following the request. seg and lockup follow state combinationally.
- Reset mid-sequence aborts the period measurement; period returns to 0.

Test Plan:
- Reset, then 3 forward steps (defaults) -> state sequence 0x03, 0x81, 0xC0, 0x60; lockup = 0; wrap = 0.
- From 0x81, dir = 1, one step -> state = 0x03, wrap = 1 for exactly one cycle, period = 1 (one counted step since the 0x03→0x81 load path is excluded: load 0x81 first).
- Reset, en = 1 forward for 255 cycles -> wrap pulses only on cycle 255, period = 255, state = 0x03. Run 255 reverse steps -> same wrap/period, and the state trace is the forward trace reversed.
- load = 1, load_data = 0x00 -> lockup = 1, seg = {0x40, 0x40}. Next en cycle -> state = 0x03, lockup = 0, no wrap.
- State 0x03, clear = 0 -> seg[6:0] = 0x30, seg[13:7] = 0x40. clear = 1 -> both 0x7F, and state stepping continues unaffected.
- load and en asserted together mid-run with load_data = 0x5A -> state = 0x5A (load wins). rst asserted with en = 1 -> state = 0x03, period = 0.

Source files
------------

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with forward/reverse stepping,
// synchronous load, all-zero lock-up recovery, period measurement and
// active-low hex seven-segment outputs for every state nibble.
module lfsr_gen #(
    parameter int                WIDTH    = 8,
    parameter logic [WIDTH-1:0]  TAP_MASK = 8'h1D,
    parameter logic [WIDTH-1:0]  SEED     = 8'h03,
    parameter int                NDIG     = (WIDTH + 3) / 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 dir,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_data,
    input  logic                 clear,
    output logic [WIDTH-1:0]     state,
    output logic                 lockup,
    output logic                 wrap,
    output logic [WIDTH-1:0]     period,
    output logic [7*NDIG-1:0]    seg
);

    logic [WIDTH-1:0]  r_state;
    logic [WIDTH-1:0]  r_step_cnt;
    logic              r_wrap;
    logic [WIDTH-1:0]  r_period;

    logic              w_fb;
    logic              w_prev_bit0;
    logic [WIDTH-1:0]  w_next;
    logic [WIDTH-1:0]  w_prev;
    logic [WIDTH-1:0]  w_step;
    logic [WIDTH-1:0]  w_cnt_inc;
    logic              w_lockup;
    logic [4*NDIG-1:0] w_pad;

    // Active-low glyph for one hex nibble; bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Forward step shifts right and injects the tap parity at the top.
    // Reverse step undoes it: shift left, and recover bit 0 from the old top
    // bit XORed with the remaining taps (each tap i now sits at position i-1).
    always_comb begin
        w_fb        = ^(r_state & TAP_MASK);
        w_next      = {w_fb, r_state[WIDTH-1:1]};
        w_prev_bit0 = r_state[WIDTH-1] ^ (^({r_state[WIDTH-2:0], 1'b0} & TAP_MASK));
        w_prev      = {r_state[WIDTH-2:0], w_prev_bit0};
        w_step      = dir ? w_prev : w_next;
        w_lockup    = (r_state == '0);
        // Saturating increment: a long forward/back excursion must not wrap the count.
        w_cnt_inc   = (r_step_cnt == '1) ? r_step_cnt : r_step_cnt + WIDTH'(1);
    end

    // State, step counter, wrap pulse and period; priority rst > load > en > hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEED;
            r_step_cnt <= '0;
            r_wrap     <= 1'b0;
            r_period   <= '0;
        end else if (load) begin
            r_state    <= load_data;
            r_step_cnt <= '0;
            r_wrap     <= 1'b0;
        end else if (en) begin
            if (w_lockup) begin
                // All-zero state is a fixed point; reseed in one enabled cycle.
                r_state    <= SEED;
                r_step_cnt <= '0;
                r_wrap     <= 1'b0;
            end else begin
                r_state <= w_step;
                if (w_step == SEED) begin
                    r_wrap     <= 1'b1;
                    r_period   <= w_cnt_inc;
                    r_step_cnt <= '0;
                end else begin
                    r_wrap     <= 1'b0;
                    r_step_cnt <= w_cnt_inc;
                end
            end
        end else begin
            r_wrap <= 1'b0;
        end
    end

    // Seven-segment bank: zero-extend state to whole nibbles, blank on clear.
    always_comb begin
        w_pad = '0;
        w_pad[WIDTH-1:0] = r_state;
        seg = '1;
        for (int k = 0; k < NDIG; k++) begin
            if (!clear) begin
                seg[7*k +: 7] = hex_to_seg(w_pad[4*k +: 4]);
            end
        end
    end

    assign state  = r_state;
    assign lockup = w_lockup;
    assign wrap   = r_wrap;
    assign period = r_period;

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed and randomized checks of lfsr_gen against a
// table-driven behavioural model, plus literal expectations that pin the model.
module tb_lfsr_gen;

    localparam int W = 8;
    localparam int ND = 2;
    localparam logic [W-1:0] MASK = 8'h1D;
    localparam logic [W-1:0] SEEDV = 8'h03;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic dir = 1'b0;
    logic load = 1'b0;
    logic [W-1:0] load_data = '0;
    logic clear = 1'b0;
    logic [W-1:0] state;
    logic lockup;
    logic wrap;
    logic [W-1:0] period;
    logic [7*ND-1:0] seg;

    always #5 clk = ~clk;

    lfsr_gen dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
        .load_data(load_data), .clear(clear), .state(state),
        .lockup(lockup), .wrap(wrap), .period(period), .seg(seg)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Successor table from the feedback rule; predecessor table is its inverse.
    logic [W-1:0] fwd_tab [256];
    logic [W-1:0] inv_tab [256];
    logic [6:0]   glyph   [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    initial begin
        for (int s = 0; s < 256; s++) begin
            int par;
            int nx;
            par = $countones(s[7:0] & MASK) % 2;
            nx  = par * 128 + s / 2;
            fwd_tab[s] = nx[7:0];
        end
        for (int s = 0; s < 256; s++) inv_tab[fwd_tab[s]] = s[7:0];
    end

    logic [W-1:0] m_state = '0;
    int           m_cnt = 0;
    logic         m_wrap = 1'b0;
    int           m_period = 0;
    logic         m_valid = 1'b0;

    function automatic logic [7*ND-1:0] exp_seg(input logic [W-1:0] s, input logic clr);
        logic [7*ND-1:0] r;
        if (clr) return '1;
        r[6:0]  = ~glyph[s[3:0]];
        r[13:7] = ~glyph[s[7:4]];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_state = SEEDV; m_cnt = 0; m_wrap = 1'b0; m_period = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            if (load) begin
                m_state = load_data; m_cnt = 0; m_wrap = 1'b0;
            end else if (en) begin
                if (m_state == 0) begin
                    m_state = SEEDV; m_cnt = 0; m_wrap = 1'b0;
                end else begin
                    m_state = dir ? inv_tab[m_state] : fwd_tab[m_state];
                    if (m_state == SEEDV) begin
                        m_wrap = 1'b1;
                        m_period = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                        m_cnt = 0;
                    end else begin
                        m_wrap = 1'b0;
                        m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                    end
                end
            end else begin
                m_wrap = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            check("state",  32'(state),  32'(m_state));
            check("lockup", 32'(lockup), 32'(m_state == 0));
            check("wrap",   32'(wrap),   32'(m_wrap));
            check("period", 32'(period), 32'(m_period));
            check("seg",    32'(seg),    32'(exp_seg(m_state, clear)));
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0; clear = 1'b0;
    endtask

    logic [W-1:0] fw_trace [256];
    int wrap_count;
    int wrap_at;

    initial begin
        tick(); tick();
        idle_inputs();
        // Reset values
        check("rst_state", 32'(state), 32'h03);
        check("rst_period", 32'(period), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        check("rst_lockup", 32'(lockup), 32'h0);
        check("rst_seg", 32'(seg), 32'h2030);

        // Three forward steps from SEED
        en = 1'b1; dir = 1'b0;
        tick(); check("fwd1", 32'(state), 32'h81);
        tick(); check("fwd2", 32'(state), 32'hC0);
        tick(); check("fwd3", 32'(state), 32'h60);
        check("fwd3_wrap", 32'(wrap), 32'h0);
        check("fwd3_lockup", 32'(lockup), 32'h0);

        // Load 0x81 then one reverse step lands on SEED
        idle_inputs(); load = 1'b1; load_data = 8'h81;
        tick(); check("load81", 32'(state), 32'h81);
        idle_inputs(); en = 1'b1; dir = 1'b1;
        tick();
        check("rev_state", 32'(state), 32'h03);
        check("rev_wrap", 32'(wrap), 32'h1);
        check("rev_period", 32'(period), 32'h1);
        idle_inputs();
        tick(); check("rev_wrap_drop", 32'(wrap), 32'h0);

        // Full forward cycle from reset
        rst = 1'b1; tick(); idle_inputs();
        fw_trace[0] = state;
        wrap_count = 0; wrap_at = -1;
        en = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 255; i++) begin
            tick();
            fw_trace[i] = state;
            if (wrap) begin wrap_count++; wrap_at = i; end
        end
        check("fwd_wrap_count", 32'(wrap_count), 32'd1);
        check("fwd_wrap_at", 32'(wrap_at), 32'd255);
        check("fwd_period", 32'(period), 32'd255);
        check("fwd_end_state", 32'(state), 32'h03);

        // Full reverse cycle retraces the forward trace backwards
        wrap_count = 0; wrap_at = -1;
        dir = 1'b1;
        for (int j = 1; j <= 255; j++) begin
            tick();
            check("rev_trace", 32'(state), 32'(fw_trace[255 - j]));
            if (wrap) begin wrap_count++; wrap_at = j; end
        end
        check("rev_wrap_count", 32'(wrap_count), 32'd1);
        check("rev_wrap_at", 32'(wrap_at), 32'd255);
        check("rev_period", 32'(period), 32'd255);

        // Lock-up and recovery
        idle_inputs(); load = 1'b1; load_data = 8'h00;
        tick();
        check("lock_flag", 32'(lockup), 32'h1);
        check("lock_seg", 32'(seg), 32'h2040);
        idle_inputs(); en = 1'b1;
        tick();
        check("recover_state", 32'(state), 32'h03);
        check("recover_lockup", 32'(lockup), 32'h0);
        check("recover_wrap", 32'(wrap), 32'h0);
        check("recover_period", 32'(period), 32'd255);

        // Display blanking does not disturb stepping
        idle_inputs();
        check("seg_03", 32'(seg), 32'h2030);
        clear = 1'b1;
        tick(); check("seg_clear", 32'(seg), 32'h3FFF);
        en = 1'b1;
        tick();
        check("clear_step_state", 32'(state), 32'h81);
        check("clear_step_seg", 32'(seg), 32'h3FFF);

        // load beats en; rst beats en
        idle_inputs(); en = 1'b1;
        repeat (5) tick();
        load = 1'b1; load_data = 8'h5A;
        tick(); check("load_wins", 32'(state), 32'h5A);
        load = 1'b0; rst = 1'b1;
        tick();
        check("rst_wins_state", 32'(state), 32'h03);
        check("rst_wins_period", 32'(period), 32'h0);

        // Randomized traffic, checked every cycle by the compare process
        idle_inputs();
        for (int c = 0; c < 4000; c++) begin
            int sel;
            rst   = ($urandom_range(0, 299) == 0);
            load  = ($urandom_range(0, 39) == 0);
            sel   = $urandom_range(0, 3);
            load_data = (sel == 0) ? 8'h00 : (sel == 1) ? SEEDV : 8'($urandom_range(0, 255));
            en    = ($urandom_range(0, 9) != 0);
            dir   = ($urandom_range(0, 7) == 0);
            clear = ($urandom_range(0, 7) == 0);
            tick();
        end
        idle_inputs();
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
